// File: rtl/test_seq_pkg.sv
// Shared types and constants for the board test sequencer.
package test_seq_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    localparam int TOHOST_PASS = 1;

    localparam int LED_PASS    = 0;
    localparam int LED_FAIL    = 1;
    localparam int LED_TIMEOUT = 2;

endpackage

// File: rtl/test_seq_heartbeat.sv
// Free-running divider that toggles a heartbeat bit every 2^DIV_WIDTH cycles.
module test_seq_heartbeat #(
    parameter int DIV_WIDTH = 22
) (
    input  logic clk,
    input  logic reset,
    output logic hb_o
);

    logic [DIV_WIDTH-1:0] div_q;
    logic                 hb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            hb_q  <= 1'b0;
        end else begin
            div_q <= div_q + DIV_WIDTH'(1);
            if (&div_q) begin
                hb_q <= ~hb_q;
            end
        end
    end

    assign hb_o = hb_q;

endmodule

// File: rtl/test_sequencer.sv
// Core reset sequencer and tohost pass/fail/timeout monitor.
// Define TEST_SEQ_HEARTBEAT_EN to blink led[LED_WIDTH-1] while the core runs.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    LED_WIDTH      = 4,
    parameter int                    CNT_WIDTH      = 32,
    parameter int                    RESET_CYCLES   = 4,
    parameter int                    TIMEOUT_CYCLES = 400,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 'h0000_1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_reset_n,
    output logic                  done,
    output logic                  pass,
    output logic [DATA_WIDTH-2:0] fail_code,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [LED_WIDTH-1:0]  led
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  core_rn_q, core_rn_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [DATA_WIDTH-2:0] fail_q, fail_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    logic                  tohost;
    logic                  hb;

`ifdef TEST_SEQ_HEARTBEAT_EN
    test_seq_heartbeat #(
        .DIV_WIDTH(22)
    ) u_heartbeat (
        .clk  (clk),
        .reset(reset),
        .hb_o (hb)
    );
`else
    assign hb = 1'b0;
`endif

    assign tohost = mem_we && (mem_addr == TOHOST_ADDR);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        core_rn_d = core_rn_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;

        case (state_q)
            HOLD: begin
                if (hold_q == HW'(RESET_CYCLES - 1)) begin
                    state_d   = RUN;
                    core_rn_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RUN: begin
                // A qualifying store takes priority over a same-cycle timeout.
                if (tohost && (mem_wdata != '0)) begin
                    done_d    = 1'b1;
                    core_rn_d = 1'b0;
                    if (mem_wdata == DATA_WIDTH'(TOHOST_PASS)) begin
                        state_d = PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = FAIL;
                        fail_d  = mem_wdata[DATA_WIDTH-1:1];
                    end
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES))) begin
                    state_d   = TIMEOUT;
                    done_d    = 1'b1;
                    core_rn_d = 1'b0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase

        led_d              = '0;
        led_d[LED_PASS]    = (state_d == PASS);
        led_d[LED_FAIL]    = (state_d == FAIL);
        led_d[LED_TIMEOUT] = (state_d == TIMEOUT);
        led_d[LED_WIDTH-1] = (state_d == RUN) && hb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HOLD;
            hold_q    <= '0;
            cnt_q     <= '0;
            core_rn_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            core_rn_q <= core_rn_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            led_q     <= led_d;
        end
    end

    assign core_reset_n = core_rn_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_code    = fail_q;
    assign cycle_count  = cnt_q;
    assign led          = led_q;

endmodule
